// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite memory slave with pipelined address/data phases, programmable wait states and a two-cycle ERROR response.
// Optional sub-word transfers with byte-lane writes are enabled by defining AHB_MEM_BYTE_STROBE_EN.
module ahb_lite_mem_slave #(
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 64,
   parameter int WAIT_STATES = 0,
   parameter int ADDR_W      = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              hsel,
   input  logic [1:0]        htrans,
   input  logic              hwrite,
   input  logic [ADDR_W-1:0] haddr,
   input  logic [2:0]        hsize,
   input  logic [DATA_W-1:0] hwdata,
   input  logic              hready,
   output logic              hreadyout,
   output logic              hresp,
   output logic [DATA_W-1:0] hrdata
);

   localparam int LSB    = $clog2(DATA_W / 8);
   localparam int IDX_W  = $clog2(DEPTH);
   localparam int NBYTES = DATA_W / 8;
   localparam int TOP    = LSB + IDX_W;

   typedef enum logic [2:0] {IDLE, WAIT, DONE, ERR1, ERR2} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [3:0]        cnt_q;
   logic              wr_q;
   logic [IDX_W-1:0]  idx_q;
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              can_accept;
   logic              accept;
   logic              out_of_range;
   logic              size_err;
   logic              addr_err;
   logic              wr_done;
   logic              rd_done;

   // Handshake: an address phase transfers on a rising edge where hsel && hready && htrans[1]
   // while this slave is not stalling; the data phase completes on the edge where hreadyout=1.
   assign can_accept = (state == IDLE) || (state == DONE) || (state == ERR2);
   assign accept     = can_accept && hsel && hready && htrans[1];

   generate
      if (ADDR_W > TOP) begin : g_range
         assign out_of_range = |haddr[ADDR_W-1:TOP];
      end else begin : g_norange
         assign out_of_range = 1'b0;
      end
   endgenerate

`ifdef AHB_MEM_BYTE_STROBE_EN
   logic [LSB-1:0]    off;
   logic [LSB-1:0]    size_mask;
   logic [NBYTES-1:0] lane_d;
   logic [NBYTES-1:0] lane_q;

   // A lane is written when it falls in the same naturally aligned block as the address.
   always_comb begin
      off       = haddr[LSB-1:0];
      size_mask = LSB'((32'd1 << hsize) - 32'd1);
      size_err  = (hsize > 3'(LSB)) || ((off & size_mask) != '0);
      lane_d    = '0;
      for (int b = 0; b < NBYTES; b++) begin
         lane_d[b] = ((LSB'(b) >> hsize) == (off >> hsize));
      end
   end
`else
   logic unused_ok;

   assign unused_ok = ^haddr[LSB-1:0];
   assign size_err  = (hsize != 3'(LSB));
`endif

   assign addr_err = out_of_range || size_err;
   assign wr_done  = (state == DONE) && wr_q;
   assign rd_done  = (state == DONE) && !wr_q;
   assign hrdata   = rd_done ? mem[idx_q] : rdata_q;

   always_comb begin
      state_nxt = state;
      hreadyout = 1'b1;
      hresp     = 1'b0;
      case (state)
         IDLE, DONE, ERR2: begin
            hresp = (state == ERR2);
            if (accept) begin
               if (addr_err)             state_nxt = ERR1;
               else if (WAIT_STATES > 0) state_nxt = WAIT;
               else                      state_nxt = DONE;
            end else begin
               state_nxt = IDLE;
            end
         end
         WAIT: begin
            hreadyout = 1'b0;
            if (cnt_q == 4'd1) state_nxt = DONE;
         end
         ERR1: begin
            hreadyout = 1'b0;
            hresp     = 1'b1;
            state_nxt = ERR2;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         idx_q   <= '0;
         rdata_q <= '0;
`ifdef AHB_MEM_BYTE_STROBE_EN
         lane_q  <= '0;
`endif
      end else begin
         state <= state_nxt;
         if (accept) begin
            wr_q  <= hwrite;
            idx_q <= haddr[LSB +: IDX_W];
            cnt_q <= 4'(WAIT_STATES);
`ifdef AHB_MEM_BYTE_STROBE_EN
            lane_q <= lane_d;
`endif
         end else if (state == WAIT) begin
            cnt_q <= cnt_q - 4'd1;
         end
         if (rd_done) rdata_q <= mem[idx_q];
      end
   end

   // Reset reloads the identity pattern, so an aborted write never leaves partial data.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= DATA_W'(i);
      end else if (wr_done) begin
`ifdef AHB_MEM_BYTE_STROBE_EN
         for (int b = 0; b < NBYTES; b++) begin
            if (lane_q[b]) mem[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
         end
`else
         mem[idx_q] <= hwdata;
`endif
      end
   end

endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// Bench for ahb_lite_mem_slave: two instances (0 and 3 wait states) against a transfer-level model.
`timescale 1ns/1ps
module tb_ahb_lite_mem_slave;

   localparam int DW = 32, DEPTH = 64, AW = 32, LSB = 2, IDXW = 6;
   localparam int WS0 = 0, WS1 = 3;

   typedef struct packed {
      logic          rdy;
      logic          resp;
      logic          chk;
      logic [DW-1:0] rd;
      logic [DW-1:0] wd;
   } exp_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          hsel [2];
   logic [1:0]    htrans [2];
   logic          hwrite [2];
   logic [AW-1:0] haddr [2];
   logic [2:0]    hsize [2];
   logic [DW-1:0] hwdata [2];
   logic          hready [2];
   logic          stall [2];
   logic          hreadyout [2];
   logic          hresp [2];
   logic [DW-1:0] hrdata [2];

   // A stall models another slave holding the shared hready low while this one is idle.
   assign hready[0] = hreadyout[0] & ~stall[0];
   assign hready[1] = hreadyout[1] & ~stall[1];

   ahb_lite_mem_slave #(.DATA_W(DW), .DEPTH(DEPTH), .WAIT_STATES(WS0), .ADDR_W(AW)) u_dut0 (
      .clk(clk), .reset(rst), .hsel(hsel[0]), .htrans(htrans[0]), .hwrite(hwrite[0]),
      .haddr(haddr[0]), .hsize(hsize[0]), .hwdata(hwdata[0]), .hready(hready[0]),
      .hreadyout(hreadyout[0]), .hresp(hresp[0]), .hrdata(hrdata[0]));

   ahb_lite_mem_slave #(.DATA_W(DW), .DEPTH(DEPTH), .WAIT_STATES(WS1), .ADDR_W(AW)) u_dut1 (
      .clk(clk), .reset(rst), .hsel(hsel[1]), .htrans(htrans[1]), .hwrite(hwrite[1]),
      .haddr(haddr[1]), .hsize(hsize[1]), .hwdata(hwdata[1]), .hready(hready[1]),
      .hreadyout(hreadyout[1]), .hresp(hresp[1]), .hrdata(hrdata[1]));

   // ---------------- model / scoreboard ----------------
   logic [DW-1:0] mdl_mem [2][DEPTH];
   logic [DW-1:0] last_rd [2];
   logic          busy [2];
   exp_t          exp_q0[$];
   exp_t          exp_q1[$];
   int            checks = 0;
   int            errors = 0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic rdy, input logic resp, input logic c,
                               input logic [DW-1:0] rd, input logic [DW-1:0] wd);
      exp_t e;
      e.rdy = rdy; e.resp = resp; e.chk = c; e.rd = rd; e.wd = wd;
      return e;
   endfunction

   task automatic q_push(input int d, input exp_t e);
      if (d == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
   endtask

   function automatic logic q_pop(input int d, output exp_t e);
      e = '0;
      if (d == 0) begin
         if (exp_q0.size() == 0) return 1'b0;
         e = exp_q0.pop_front();
      end else begin
         if (exp_q1.size() == 0) return 1'b0;
         e = exp_q1.pop_front();
      end
      return 1'b1;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < DEPTH; i++) mdl_mem[d][i] = DW'(i);
         last_rd[d] = '0;
         busy[d]    = 1'b0;
      end
      exp_q0.delete();
      exp_q1.delete();
   endtask

   // Expected data-phase cycles of one accepted transfer; memory updates in transfer order.
   task automatic model_accept(input int d, input logic wr, input logic [AW-1:0] addr,
                               input logic [2:0] sz, input logic [DW-1:0] wd);
      int   idx, nws, off;
      logic bad;
      idx = int'((addr >> LSB) % DEPTH);
      off = int'(addr % (DW / 8));
      bad = (addr >> (LSB + IDXW)) != 0;
`ifdef AHB_MEM_BYTE_STROBE_EN
      if (int'(sz) > LSB) bad = 1'b1;
      else if ((off % (1 << sz)) != 0) bad = 1'b1;
`else
      if (int'(sz) != LSB) bad = 1'b1;
`endif
      nws = (d == 1) ? WS1 : WS0;
      if (bad) begin
         q_push(d, mk(1'b0, 1'b1, 1'b0, '0, wd));
         q_push(d, mk(1'b1, 1'b1, 1'b0, '0, wd));
      end else begin
         for (int i = 0; i < nws; i++) q_push(d, mk(1'b0, 1'b0, 1'b0, '0, wd));
         if (wr) begin
`ifdef AHB_MEM_BYTE_STROBE_EN
            for (int b = off; b < off + (1 << sz); b++) mdl_mem[d][idx][8*b +: 8] = wd[8*b +: 8];
`else
            mdl_mem[d][idx] = wd;
`endif
            q_push(d, mk(1'b1, 1'b0, 1'b0, '0, wd));
         end else begin
            q_push(d, mk(1'b1, 1'b0, 1'b1, mdl_mem[d][idx], wd));
         end
      end
   endtask

   // Compare process: every cycle out of reset, for both instances.
   initial begin
      exp_t e;
      logic got;
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            if (rst) begin
               hwdata[d] = $urandom;
            end else begin
               got     = q_pop(d, e);
               busy[d] = got;
               if (!got) e = mk(1'b1, 1'b0, 1'b0, '0, $urandom);
               if (e.chk) last_rd[d] = e.rd;
               chk($sformatf("dev%0d_hreadyout", d), DW'(hreadyout[d]), DW'(e.rdy));
               chk($sformatf("dev%0d_hresp", d), DW'(hresp[d]), DW'(e.resp));
               chk($sformatf("dev%0d_hrdata", d), hrdata[d], last_rd[d]);
               hwdata[d] = e.wd;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive_idle(input int d);
      hsel[d] = 1'b0; htrans[d] = 2'b00; hwrite[d] = $urandom_range(0, 1);
      haddr[d] = $urandom; hsize[d] = 3'($urandom_range(0, 7)); stall[d] = 1'b0;
   endtask

   // Junk NONSEQ while this slave stalls: hready is low, so it must be ignored.
   task automatic drive_garbage(input int d);
      hsel[d] = 1'b1; htrans[d] = 2'b10; hwrite[d] = 1'b1;
      haddr[d] = AW'($urandom_range(0, 255)); hsize[d] = 3'd2; stall[d] = 1'b0;
   endtask

   task automatic wait_ready(input int d);
      int n = 0;
      while (hreadyout[d] !== 1'b1 && n < 40) begin
         drive_garbage(d);
         n++;
         @(negedge clk); #1;
      end
      if (n >= 40) begin
         checks++; errors++;
         $display("FAIL dev%0d_ready_timeout actual hreadyout=0 required 1 within 40 cycles", d);
      end
   endtask

   task automatic issue(input int d, input logic sel, input logic [1:0] tr, input logic wr,
                        input logic [AW-1:0] addr, input logic [2:0] sz,
                        input logic [DW-1:0] wd, input logic stl);
      wait_ready(d);
      if (busy[d]) stl = 1'b0;
      hsel[d] = sel; htrans[d] = tr; hwrite[d] = wr; haddr[d] = addr; hsize[d] = sz; stall[d] = stl;
      if (sel && tr[1] && !stl) model_accept(d, wr, addr, sz, wd);
      @(negedge clk); #1;
      drive_idle(d);
   endtask

   task automatic do_xfer(input int d, input logic wr, input logic [AW-1:0] addr,
                          input logic [2:0] sz, input logic [DW-1:0] wd,
                          output logic [DW-1:0] rd, output logic rsp, output int waits);
      wait_ready(d);
      hsel[d] = 1'b1; htrans[d] = 2'b10; hwrite[d] = wr; haddr[d] = addr; hsize[d] = sz; stall[d] = 1'b0;
      model_accept(d, wr, addr, sz, wd);
      @(negedge clk); #1;
      waits = 0;
      while (hreadyout[d] !== 1'b1 && waits < 40) begin
         drive_garbage(d);
         waits++;
         @(negedge clk); #1;
      end
      drive_idle(d);
      rd  = hrdata[d];
      rsp = hresp[d];
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [DW-1:0] rd;
      logic          rsp;
      int            w;
      drive_idle(0);
      drive_idle(1);
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("reset_hreadyout_dev%0d", d), DW'(hreadyout[d]), 32'd1);
         chk($sformatf("reset_hresp_dev%0d", d), DW'(hresp[d]), 32'd0);
         chk($sformatf("reset_hrdata_dev%0d", d), hrdata[d], 32'd0);
      end
      rst = 1'b0;
      @(negedge clk); #1;

      do_xfer(0, 1'b0, 32'h14, 3'd2, '0, rd, rsp, w);
      chk("rd14_data", rd, 32'h0000_0005);
      chk("rd14_resp", DW'(rsp), 32'd0);
      chk("rd14_waits", DW'(w), 32'd0);

      do_xfer(0, 1'b1, 32'h08, 3'd2, 32'hDEAD_BEEF, rd, rsp, w);
      chk("b2b_wr_waits", DW'(w), 32'd0);
      do_xfer(0, 1'b0, 32'h08, 3'd2, '0, rd, rsp, w);
      chk("b2b_rd_waits", DW'(w), 32'd0);
      chk("b2b_rd_data", rd, 32'hDEAD_BEEF);

      do_xfer(1, 1'b0, 32'h04, 3'd2, '0, rd, rsp, w);
      chk("ws3_waits", DW'(w), 32'd3);
      chk("ws3_data", rd, 32'h0000_0001);

      do_xfer(0, 1'b1, 32'h100, 3'd2, 32'h1234_5678, rd, rsp, w);
      chk("oor_err1_cycles", DW'(w), 32'd1);
      chk("oor_err2_resp", DW'(rsp), 32'd1);
      do_xfer(0, 1'b0, 32'h00, 3'd2, '0, rd, rsp, w);
      chk("oor_nowrite_data", rd, 32'h0000_0000);
      chk("oor_nowrite_resp", DW'(rsp), 32'd0);

`ifdef AHB_MEM_BYTE_STROBE_EN
      do_xfer(0, 1'b1, 32'h11, 3'd0, 32'h5555_AA55, rd, rsp, w);
      chk("byte_wr_resp", DW'(rsp), 32'd0);
      do_xfer(0, 1'b0, 32'h10, 3'd2, '0, rd, rsp, w);
      chk("byte_rd_data", rd, 32'h0000_AA04);
      do_xfer(0, 1'b1, 32'h11, 3'd1, 32'h0000_BBBB, rd, rsp, w);
      chk("half_misalign_resp", DW'(rsp), 32'd1);
`else
      do_xfer(0, 1'b1, 32'h11, 3'd0, 32'h0000_AA00, rd, rsp, w);
      chk("byte_err_resp", DW'(rsp), 32'd1);
      chk("byte_err_cycles", DW'(w), 32'd1);
`endif

      // Reset during the second wait cycle of a write to 0x0C.
      wait_ready(1);
      hsel[1] = 1'b1; htrans[1] = 2'b10; hwrite[1] = 1'b1; haddr[1] = 32'h0C; hsize[1] = 3'd2;
      model_accept(1, 1'b1, 32'h0C, 3'd2, 32'hCAFE_F00D);
      @(negedge clk); #1;
      drive_idle(1);
      @(negedge clk); #1;
      chk("midreset_in_wait", DW'(hreadyout[1]), 32'd0);
      rst = 1'b1;
      #1;
      chk("midreset_hreadyout", DW'(hreadyout[1]), 32'd1);
      chk("midreset_hresp", DW'(hresp[1]), 32'd0);
      chk("midreset_hrdata", hrdata[1], 32'd0);
      model_reset();
      @(negedge clk); #1;
      rst = 1'b0;
      @(negedge clk); #1;
      do_xfer(1, 1'b0, 32'h0C, 3'd2, '0, rd, rsp, w);
      chk("midreset_rd0c", rd, 32'h0000_0003);

      for (int n = 0; n < 700; n++) begin
         int            d, idx;
         logic          sel, wr, stl;
         logic [1:0]    tr;
         logic [AW-1:0] a;
         logic [2:0]    sz;
         d   = $urandom_range(0, 1);
         sel = ($urandom_range(0, 9) != 0);
         tr  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
         wr  = $urandom_range(0, 1);
         idx = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, DEPTH - 1);
         a   = (AW'(idx) << LSB) | AW'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) a = a | (AW'(1) << $urandom_range(LSB + IDXW, AW - 1));
`ifdef AHB_MEM_BYTE_STROBE_EN
         sz = 3'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) a = a & ~(AW'((1 << sz) - 1));
`else
         sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
`endif
         stl = ($urandom_range(0, 7) == 0);
         issue(d, sel, tr, wr, a, sz, $urandom, stl);
      end

      wait_ready(0);
      wait_ready(1);
      repeat (6) @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
